// File: rtl/imm_pkg.sv
// imm_pkg: definitions shared by the immediate-extension sequencer.
//   - format-class encodings (also used on the extender's Ctrl input)
//   - opcode prefixes used by the inline decoder
//   - fixed accept-to-result latency for legal opcodes
//   - sequencer state encoding
package imm_pkg;

  // Cycles from the accepting edge until OutValid rises, for legal opcodes.
  localparam int SEQ_DEPTH = 3;

  // Format classes. The same 3-bit code drives the extender's Ctrl input.
  localparam logic [2:0] CLS_I    = 3'b000;
  localparam logic [2:0] CLS_D    = 3'b001;
  localparam logic [2:0] CLS_B    = 3'b010;
  localparam logic [2:0] CLS_CB   = 3'b011;
  localparam logic [2:0] CLS_MOVZ = 3'b100;

  // Opcode prefixes. Each constant is only as wide as the field it is
  // compared against: B uses [31:26], CB [31:25], D [31:21], MOVZ [31:23],
  // and the I-type group [31:22].
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [6:0]  OPC_CB   = 7'b1011010;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
  localparam logic [9:0]  OPC_ORRI = 10'b1011001000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_EXTEND,
    S_SCALE,
    S_OUT
  } state_t;

endpackage

// File: rtl/imm_scale.sv
// imm_scale: combinational final scaling of an extended immediate.
// Ports:
//   cls    - format class of the instruction
//   hw     - MOVZ half-word select (Instr[22:21])
//   value  - immediate as returned by the external extender
//   scaled - immediate after class-specific scaling
module imm_scale
  import imm_pkg::*;
#(
  parameter int IMM_W = 64
) (
  input  logic [2:0]       cls,
  input  logic [1:0]       hw,
  input  logic [IMM_W-1:0] value,
  output logic [IMM_W-1:0] scaled
);

  logic [IMM_W-1:0] field16;

  always_comb begin
    // The extender's MOVZ result still carries the hw bits above imm16,
    // so keep only the 16-bit field before placing it.
    field16 = {{(IMM_W-16){1'b0}}, value[15:0]};
    scaled  = value;
    case (cls)
      // Branch offsets are word counts; sign was already extended.
      CLS_B, CLS_CB: scaled = value << 2;
      CLS_MOVZ:      scaled = field16 << {hw, 4'b0000};
      default:       scaled = value;
    endcase
  end

endmodule

// File: rtl/imm_seq_ctrl.sv
// imm_seq_ctrl: sequencer for the CPU immediate-extension path.
// Accepts one instruction per InValid/InReady handshake, decodes its format
// class, drives the external extender, captures its result, scales it and
// presents the registered immediate downstream under OutValid/OutReady.
// Ports:
//   CLK, resetl      - clock and synchronous active-low reset
//   Flush            - synchronous abort back to IDLE
//   InValid/InReady  - instruction handshake (InReady only in IDLE)
//   Instr            - instruction word
//   ExtImm26/ExtCtrl - registered inputs to the external extender
//   ExtBusImm        - extender result
//   OutValid/OutReady- result handshake
//   OutImm/OutClass  - scaled immediate and its format class
//   OutErr           - unsupported opcode
module imm_seq_ctrl
  import imm_pkg::*;
#(
  parameter int IMM_W = 64
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  output logic [25:0]      ExtImm26,
  output logic [2:0]       ExtCtrl,
  input  logic [IMM_W-1:0] ExtBusImm,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [IMM_W-1:0] OutImm,
  output logic [2:0]       OutClass,
  output logic             OutErr
);

  state_t           state_q, state_d;
  logic [25:0]      ext_imm26_q, ext_imm26_d;
  logic [2:0]       ext_ctrl_q, ext_ctrl_d;
  logic [1:0]       hw_q, hw_d;
  logic             illegal_q, illegal_d;
  logic [IMM_W-1:0] captured_q, captured_d;
  logic [IMM_W-1:0] out_imm_q, out_imm_d;
  logic [2:0]       out_class_q, out_class_d;
  logic             out_err_q, out_err_d;

  logic             dec_legal;
  logic [2:0]       dec_class;
  logic [IMM_W-1:0] scaled_imm;

  // Opcode decode, first match wins.
  always_comb begin
    dec_legal = 1'b1;
    dec_class = CLS_I;
    if (Instr[31:26] == OPC_B) begin
      dec_class = CLS_B;
    end else if (Instr[31:25] == OPC_CB) begin
      dec_class = CLS_CB;
    end else if (Instr[31:21] == OPC_LDUR || Instr[31:21] == OPC_STUR) begin
      dec_class = CLS_D;
    end else if (Instr[31:23] == OPC_MOVZ) begin
      dec_class = CLS_MOVZ;
    end else if (Instr[31:22] == OPC_ADDI || Instr[31:22] == OPC_SUBI ||
                 Instr[31:22] == OPC_ANDI || Instr[31:22] == OPC_ORRI) begin
      dec_class = CLS_I;
    end else begin
      dec_legal = 1'b0;
    end
  end

  imm_scale #(
    .IMM_W (IMM_W)
  ) u_scale (
    .cls    (ext_ctrl_q),
    .hw     (hw_q),
    .value  (captured_q),
    .scaled (scaled_imm)
  );

  always_comb begin
    state_d     = state_q;
    ext_imm26_d = ext_imm26_q;
    ext_ctrl_d  = ext_ctrl_q;
    hw_d        = hw_q;
    illegal_d   = illegal_q;
    captured_d  = captured_q;
    out_imm_d   = out_imm_q;
    out_class_d = out_class_q;
    out_err_d   = out_err_q;

    if (Flush) begin
      // Abort: data registers hold, only the result tag is cleared.
      state_d   = S_IDLE;
      out_err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (InValid) begin
            hw_d      = Instr[22:21];
            illegal_d = ~dec_legal;
            if (dec_legal) begin
              // Extender inputs only move on a legal accept to limit toggling.
              ext_imm26_d = Instr[25:0];
              ext_ctrl_d  = dec_class;
              state_d     = S_DRIVE;
            end else begin
              // Illegal opcodes skip the extender but still spend one cycle
              // in SCALE, which loads the error result.
              state_d = S_SCALE;
            end
          end
        end
        S_DRIVE: begin
          state_d = S_EXTEND;
        end
        S_EXTEND: begin
          captured_d = ExtBusImm;
          state_d    = S_SCALE;
        end
        S_SCALE: begin
          if (illegal_q) begin
            out_imm_d   = '0;
            out_class_d = CLS_I;
            out_err_d   = 1'b1;
          end else begin
            out_imm_d   = scaled_imm;
            out_class_d = ext_ctrl_q;
            out_err_d   = 1'b0;
          end
          state_d = S_OUT;
        end
        S_OUT: begin
          if (OutReady) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q     <= S_IDLE;
      ext_imm26_q <= '0;
      ext_ctrl_q  <= CLS_MOVZ;
      hw_q        <= '0;
      illegal_q   <= 1'b0;
      captured_q  <= '0;
      out_imm_q   <= '0;
      out_class_q <= CLS_I;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_imm26_q <= ext_imm26_d;
      ext_ctrl_q  <= ext_ctrl_d;
      hw_q        <= hw_d;
      illegal_q   <= illegal_d;
      captured_q  <= captured_d;
      out_imm_q   <= out_imm_d;
      out_class_q <= out_class_d;
      out_err_q   <= out_err_d;
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = (state_q == S_OUT);
  assign ExtImm26 = ext_imm26_q;
  assign ExtCtrl  = ext_ctrl_q;
  assign OutImm   = out_imm_q;
  assign OutClass = out_class_q;
  assign OutErr   = out_err_q;

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// tb_imm_seq_ctrl: self-checking bench for imm_seq_ctrl.
// Contains a model of the external immediate extender, a field-level
// reference model of the expected immediate, a table of directed vectors,
// hand-written backpressure/flush/reset sequences and a random phase.
module tb_imm_seq_ctrl;
  import imm_pkg::*;

  logic        CLK;
  logic        resetl;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [25:0] ExtImm26;
  logic [2:0]  ExtCtrl;
  logic [63:0] ExtBusImm;
  logic        OutValid;
  logic        OutReady;
  logic [63:0] OutImm;
  logic [2:0]  OutClass;
  logic        OutErr;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  cls;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  imm_seq_ctrl #(
    .IMM_W (64)
  ) dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .Flush     (Flush),
    .InValid   (InValid),
    .InReady   (InReady),
    .Instr     (Instr),
    .ExtImm26  (ExtImm26),
    .ExtCtrl   (ExtCtrl),
    .ExtBusImm (ExtBusImm),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutImm    (OutImm),
    .OutClass  (OutClass),
    .OutErr    (OutErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External extender: sign/zero extends the field selected by Ctrl.
  // The MOVZ field is returned with the hw bits still attached.
  always_comb begin
    ExtBusImm = '0;
    case (ExtCtrl)
      3'b000: ExtBusImm = {52'b0, ExtImm26[21:10]};
      3'b001: ExtBusImm = {{55{ExtImm26[20]}}, ExtImm26[20:12]};
      3'b010: ExtBusImm = {{38{ExtImm26[25]}}, ExtImm26[25:0]};
      3'b011: ExtBusImm = {{45{ExtImm26[23]}}, ExtImm26[23:5]};
      3'b100: ExtBusImm = {46'b0, ExtImm26[22:5]};
      default: ExtBusImm = '0;
    endcase
  end

  // Reference model working on instruction fields with plain arithmetic.
  function automatic void refModel(input logic [31:0] ins, output logic [63:0] imm,
                                   output logic [2:0] cls, output logic err);
    longint v;
    imm = '0;
    cls = 3'd0;
    err = 1'b0;
    if ((ins & 32'hFC00_0000) == 32'h1400_0000) begin
      cls = 3'd2;
      v   = longint'($signed(ins[25:0]));
      imm = 64'(v * 4);
    end else if ((ins & 32'hFE00_0000) == 32'hB400_0000) begin
      cls = 3'd3;
      v   = longint'($signed(ins[23:5]));
      imm = 64'(v * 4);
    end else if ((ins & 32'hFFA0_0000) == 32'hF800_0000) begin
      cls = 3'd1;
      v   = longint'($signed(ins[20:12]));
      imm = 64'(v);
    end else if ((ins & 32'hFF80_0000) == 32'hD280_0000) begin
      cls = 3'd4;
      imm = 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
    end else if ((ins & 32'hFFC0_0000) == 32'h9100_0000 ||
                 (ins & 32'hFFC0_0000) == 32'hD100_0000 ||
                 (ins & 32'hFFC0_0000) == 32'h9200_0000 ||
                 (ins & 32'hFFC0_0000) == 32'hB200_0000) begin
      cls = 3'd0;
      imm = 64'(ins[21:10]);
    end else begin
      err = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    resetl = 1'b0;
    @(negedge CLK);
    resetl = 1'b1;
  endtask

  // One full transaction starting and ending at a falling edge.
  task automatic applyStimulus(input string name, input logic [31:0] instr,
                               input logic [63:0] exp_imm, input logic [2:0] exp_cls,
                               input logic exp_err, input int ready_delay);
    int lat;
    checkOutput({name, " in_ready_idle"}, 64'(InReady), 64'd1);
    InValid = 1'b1;
    Instr   = instr;
    @(negedge CLK);
    InValid = 1'b0;
    Instr   = $urandom;
    checkOutput({name, " in_ready_busy"}, 64'(InReady), 64'd0);
    if (!exp_err) begin
      checkOutput({name, " ext_ctrl"}, 64'(ExtCtrl), 64'(exp_cls));
      checkOutput({name, " ext_imm26"}, 64'(ExtImm26), 64'(instr[25:0]));
    end
    lat = 0;
    while (!OutValid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    checkOutput({name, " latency"}, 64'(lat), exp_err ? 64'd1 : 64'(SEQ_DEPTH));
    if (OutValid) begin
      checkOutput({name, " out_imm"}, OutImm, exp_imm);
      checkOutput({name, " out_class"}, 64'(OutClass), 64'(exp_cls));
      checkOutput({name, " out_err"}, 64'(OutErr), 64'(exp_err));
      repeat (ready_delay) @(negedge CLK);
      checkOutput({name, " out_imm_hold"}, OutImm, exp_imm);
      OutReady = 1'b1;
      @(negedge CLK);
      OutReady = 1'b0;
      checkOutput({name, " out_valid_done"}, 64'(OutValid), 64'd0);
    end else begin
      doReset();
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " in_ready"}, 64'(InReady), 64'd1);
    checkOutput({name, " out_valid"}, 64'(OutValid), 64'd0);
    checkOutput({name, " out_err"}, 64'(OutErr), 64'd0);
    checkOutput({name, " out_imm"}, OutImm, 64'd0);
    checkOutput({name, " out_class"}, 64'(OutClass), 64'd0);
    checkOutput({name, " ext_ctrl"}, 64'(ExtCtrl), 64'd4);
    checkOutput({name, " ext_imm26"}, 64'(ExtImm26), 64'd0);
  endtask

  initial begin
    logic [63:0] e_imm;
    logic [2:0]  e_cls;
    logic        e_err;
    logic [31:0] r;
    logic [31:0] ins;
    logic [63:0] held;
    logic [9:0]  i_codes[4];
    int          lat;

    tests_run    = 0;
    tests_failed = 0;
    i_codes      = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};

    vecs[0]  = '{"addi",        32'h9100_1441, 64'h0000_0000_0000_0005, 3'd0, 1'b0};
    vecs[1]  = '{"ldur_neg8",   32'hF85F_8022, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0};
    vecs[2]  = '{"b_minus1",    32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
    vecs[3]  = '{"cbz_16",      32'hB400_0203, 64'h0000_0000_0000_0040, 3'd3, 1'b0};
    vecs[4]  = '{"movz_hw2",    32'hD2D7_DDE4, 64'h0000_BEEF_0000_0000, 3'd4, 1'b0};
    vecs[5]  = '{"zero_instr",  32'h0000_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b1};
    vecs[6]  = '{"subi_max",    32'hD13F_FC00, 64'h0000_0000_0000_0FFF, 3'd0, 1'b0};
    vecs[7]  = '{"cbnz_minneg", 32'hB580_0000, 64'hFFFF_FFFF_FFF0_0000, 3'd3, 1'b0};
    vecs[8]  = '{"movz_hw3",    32'hD2FF_FFE0, 64'hFFFF_0000_0000_0000, 3'd4, 1'b0};
    vecs[9]  = '{"stur_255",    32'hF80F_F000, 64'h0000_0000_0000_00FF, 3'd1, 1'b0};
    vecs[10] = '{"orri",        32'hB204_8C00, 64'h0000_0000_0000_0123, 3'd0, 1'b0};
    vecs[11] = '{"andi",        32'h9200_0400, 64'h0000_0000_0000_0001, 3'd0, 1'b0};
    vecs[12] = '{"all_ones",    32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 3'd0, 1'b1};
    vecs[13] = '{"movz_hw0",    32'hD282_4680, 64'h0000_0000_0000_1234, 3'd4, 1'b0};

    resetl   = 1'b0;
    Flush    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    Instr    = 32'h0;
    repeat (2) @(negedge CLK);
    checkResetValues("reset");
    resetl = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].name, vecs[i].instr, vecs[i].imm, vecs[i].cls, vecs[i].err, i % 3);
    end

    // Backpressure: result held while a second instruction waits.
    InValid = 1'b1;
    Instr   = 32'h9100_1441;
    @(negedge CLK);
    Instr = 32'hF85F_8022;
    lat = 0;
    while (!OutValid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    checkOutput("bp latency", 64'(lat), 64'(SEQ_DEPTH));
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checkOutput("bp out_imm_stable", OutImm, 64'h5);
      checkOutput("bp in_ready_low", 64'(InReady), 64'd0);
      checkOutput("bp out_valid_high", 64'(OutValid), 64'd1);
    end
    OutReady = 1'b1;
    @(negedge CLK);
    OutReady = 1'b0;
    checkOutput("bp transfer idle", 64'(InReady), 64'd1);
    checkOutput("bp transfer valid_low", 64'(OutValid), 64'd0);
    @(negedge CLK);
    InValid = 1'b0;
    checkOutput("bp second accepted", 64'(InReady), 64'd0);
    checkOutput("bp second ext_ctrl", 64'(ExtCtrl), 64'd1);
    lat = 0;
    while (!OutValid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    checkOutput("bp second out_imm", OutImm, 64'hFFFF_FFFF_FFFF_FFF8);
    OutReady = 1'b1;
    @(negedge CLK);
    OutReady = 1'b0;

    // Flush while in EXTEND.
    InValid = 1'b1;
    Instr   = 32'h9100_1441;
    @(negedge CLK);
    InValid = 1'b0;
    @(negedge CLK);
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    checkOutput("flush_ext out_valid", 64'(OutValid), 64'd0);
    checkOutput("flush_ext in_ready", 64'(InReady), 64'd1);
    repeat (4) @(negedge CLK);
    checkOutput("flush_ext stays_idle", 64'(OutValid), 64'd0);

    // Flush beats InValid in IDLE: extender inputs must not move.
    Flush   = 1'b1;
    InValid = 1'b1;
    Instr   = 32'h17FF_FFFF;
    @(negedge CLK);
    Flush   = 1'b0;
    InValid = 1'b0;
    checkOutput("flush_idle in_ready", 64'(InReady), 64'd1);
    checkOutput("flush_idle ext_ctrl", 64'(ExtCtrl), 64'd0);

    // Flush in OUT clears the error tag.
    InValid = 1'b1;
    Instr   = 32'h0000_0000;
    @(negedge CLK);
    InValid = 1'b0;
    @(negedge CLK);
    checkOutput("flush_out err_set", 64'(OutErr), 64'd1);
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    checkOutput("flush_out valid", 64'(OutValid), 64'd0);
    checkOutput("flush_out err", 64'(OutErr), 64'd0);
    checkOutput("flush_out in_ready", 64'(InReady), 64'd1);

    // Load a nonzero result, then reset while the next one is in SCALE.
    applyStimulus("pre_reset", 32'hD2D7_DDE4, 64'h0000_BEEF_0000_0000, 3'd4, 1'b0, 0);
    InValid = 1'b1;
    Instr   = 32'h9100_1441;
    @(negedge CLK);
    InValid = 1'b0;
    repeat (2) @(negedge CLK);
    resetl = 1'b0;
    @(negedge CLK);
    checkResetValues("reset_scale");
    resetl = 1'b1;
    @(negedge CLK);

    // Random phase against the field-level reference model.
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      case ($urandom_range(0, 5))
        0: ins = {6'b000101, r[25:0]};
        1: ins = {7'b1011010, r[24:0]};
        2: ins = {9'b111110000, r[22], 1'b0, r[20:0]};
        3: ins = {9'b110100101, r[22:0]};
        4: ins = {i_codes[r[23:22]], r[21:0]};
        default: ins = r;
      endcase
      refModel(ins, e_imm, e_cls, e_err);
      held = e_imm;
      applyStimulus($sformatf("rand%0d", i), ins, held, e_cls, e_err, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
